// File: rtl/seg_display_scheduler.sv
// Round-robin arbiter sharing one 3-bit seven-segment decoder between four requesters.
// Each grant is shown for HOLD cycles, acknowledged with a one-cycle pulse, then followed by a blank cycle.
module seg_display_scheduler #(
  parameter int unsigned HOLD   = 8,
  parameter int unsigned HOLD_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [11:0] code_in,
  input  logic        perm_in,
  output logic        MSB,
  output logic        B,
  output logic        LSB,
  output logic        Perm,
  output logic        Func,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [HOLD_W-1:0]   r_cnt;

  logic                w_found;
  logic [1:0]          w_win;
  logic [1:0]          w_idx;
  logic [2:0]          w_codes [4];

  // First asserted request at or after r_ptr, wrapping modulo 4
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      w_codes[k] = code_in[3*k +: 3];
      w_idx      = r_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_cnt           <= '0;
      {MSB, B, LSB}   <= '0;
      Perm            <= 1'b0;
      Func            <= 1'b0;
      ack             <= '0;
      grant_id        <= '0;
      busy            <= 1'b0;
    end else begin
      Perm <= perm_in;
      case (r_state)
        S_IDLE: begin
          ack <= '0;
          if (perm_in && w_found) begin
            {MSB, B, LSB} <= w_codes[w_win];
            grant_id      <= w_win;
            r_cnt         <= HOLD_W'(HOLD - 1);
            Func          <= 1'b1;
            busy          <= 1'b1;
            r_state       <= S_SHOW;
          end else begin
            Func <= 1'b0;
            busy <= 1'b0;
          end
        end
        S_SHOW: begin
          // Loss of permission abandons the display without ack or pointer advance
          if (!perm_in) begin
            Func    <= 1'b0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            Func    <= 1'b0;
            ack     <= 4'b0001 << grant_id;
            r_ptr   <= grant_id + 2'd1;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          ack     <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with HOLD=8: reset, fairness, single request,
// abort and re-grant, early request drop, and reset in the middle of a display.
module tb_seg_display_scheduler;

  localparam int unsigned HOLD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] code_in;
  logic        perm_in;
  logic        MSB, B, LSB, Perm, Func, busy;
  logic [3:0]  ack;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_start;

  // requester codes: c3=011 c2=101 c1=110 c0=001
  localparam logic [2:0] C0 = 3'b001, C1 = 3'b110, C2 = 3'b101, C3 = 3'b011;

  seg_display_scheduler #(.HOLD(HOLD), .HOLD_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .code_in(code_in), .perm_in(perm_in),
    .MSB(MSB), .B(B), .LSB(LSB), .Perm(Perm), .Func(Func),
    .ack(ack), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] code_of(input int id);
    case (id)
      0: return C0;
      1: return C1;
      2: return C2;
      default: return C3;
    endcase
  endfunction

  task automatic wait_func(input string tag);
    int n = 0;
    while (Func !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(Func), 32'd1);
  endtask

  // Called while Func is high; counts remaining Func cycles and checks the ack cycle
  task automatic measure_display(input int id, input int already, input string tag);
    int n = already;
    while (Func === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check({tag, "_len"}, 32'(n), 32'(HOLD));
    check({tag, "_ack"}, 32'(ack), 32'(4'b0001 << id));
    check({tag, "_busy_gap"}, 32'(busy), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req = 4'hF; perm_in = 1'b1;
    code_in = {C3, C2, C1, C0};

    // reset held two cycles with everything requesting
    tick();
    check("rst_outs_1", 32'({MSB, B, LSB, Perm, Func, ack, grant_id, busy}), 32'd0);
    tick();
    check("rst_outs_2", 32'({MSB, B, LSB, Perm, Func, ack, grant_id, busy}), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_func", 32'(Func), 32'd1);
    check("post_rst_gid", 32'(grant_id), 32'd0);
    check("post_rst_perm", 32'(Perm), 32'd1);

    // fairness: continuous requests, each line drops for one cycle after its ack
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_func("fair_rise");
        check("fair_spacing", 32'(cyc - last_start), 32'(HOLD + 2));
      end
      last_start = cyc;
      check("fair_gid", 32'(grant_id), 32'(k % 4));
      check("fair_code", 32'({MSB, B, LSB}), 32'(code_of(k % 4)));
      measure_display(k % 4, 0, "fair");
      if (k < 4) begin
        req[k % 4] = 1'b0;
        tick();
        req[k % 4] = 1'b1;
      end
    end
    req = 4'b0000;

    // single request from requester 2, held through a second grant
    req = 4'b0100;
    wait_func("single_rise");
    last_start = cyc;
    check("single_code", 32'({MSB, B, LSB}), 32'b101);
    check("single_gid", 32'(grant_id), 32'd2);
    measure_display(2, 0, "single");
    check("single_gap_func", 32'(Func), 32'd0);
    tick();
    check("single_idle_func", 32'(Func), 32'd0);
    check("single_idle_ack", 32'(ack), 32'd0);
    tick();
    check("single_regrant", 32'(Func), 32'd1);
    check("single_regrant_spacing", 32'(cyc - last_start), 32'(HOLD + 2));
    measure_display(2, 0, "single2");
    req = 4'b0000;

    // abort: requester 1 loses permission in its third SHOW cycle
    req = 4'b0010;
    wait_func("abort_rise");
    check("abort_gid", 32'(grant_id), 32'd1);
    tick();
    tick();
    perm_in = 1'b0;
    req = 4'b0110;
    tick();
    check("abort_func", 32'(Func), 32'd0);
    check("abort_perm", 32'(Perm), 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    tick();
    check("abort_hold_func", 32'(Func), 32'd0);
    check("abort_hold_ack", 32'(ack), 32'd0);
    check("abort_code_kept", 32'({MSB, B, LSB}), 32'(C1));
    perm_in = 1'b1;
    tick();
    check("reperm_func", 32'(Func), 32'd1);
    check("reperm_gid", 32'(grant_id), 32'd1);
    measure_display(1, 0, "reperm");
    req = 4'b0000;

    // early request drop by requester 3 in its second SHOW cycle
    req = 4'b1000;
    wait_func("early_rise");
    check("early_gid", 32'(grant_id), 32'd3);
    tick();
    req = 4'b0000;
    measure_display(3, 1, "early");

    // advance the pointer away from 0, then reset in the middle of a display
    req = 4'b0010;
    wait_func("pre_rst_rise");
    measure_display(1, 0, "pre_rst");
    req = 4'b0100;
    wait_func("mid_rise");
    check("mid_gid", 32'(grant_id), 32'd2);
    tick();
    tick();
    tick();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    check("mid_rst_outs", 32'({MSB, B, LSB, Perm, Func, ack, grant_id, busy}), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_regrant_func", 32'(Func), 32'd1);
    check("mid_rst_regrant_gid", 32'(grant_id), 32'd0);
    check("mid_rst_regrant_code", 32'({MSB, B, LSB}), 32'(C0));
    measure_display(0, 0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
